wb_bus_arbiter: RTL and testbench

- Two-requester round-robin arbiter for one shared 32-bit write-back bus.
- Internally drives the 2:1 word-select (0 = source A, 1 = source B), registers the selected word and presents it downstream with a valid/ready handshake.
- Sits between the ALU-result and load-data producers and the register-file write port.
- Also keeps saturating per-source transfer counters for debug.

---
 rtl/wb_bus_arbiter.sv | 89 ++++++++
 tb/tb_wb_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Two-source round-robin write-back arbiter.
// Selects between source A and source B and registers the chosen word into a
// single output stage with a valid/ready handshake. Tracks per-source
// transfer counts that saturate rather than wrap.
module wb_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] InA,
    input  logic                  ValidA,
    output logic                  ReadyA,
    input  logic [DATA_WIDTH-1:0] InB,
    input  logic                  ValidB,
    output logic                  ReadyB,
    output logic [DATA_WIDTH-1:0] Out,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  OutSel,
    output logic [CNT_WIDTH-1:0]  CntA,
    output logic [CNT_WIDTH-1:0]  CntB
);

    // PRI_A: A wins a tie; PRI_B: B wins a tie.
    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    pri_t state;

    logic load;
    logic grant_a;
    logic grant_b;
    logic xfer_a;
    logic xfer_b;
    logic drain;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        r = (&v) ? v : v + 1'b1;
        return r;
    endfunction

    // Grant and handshake decode; uses only valids, priority state and the
    // output stage occupancy, never the data words. Ready is forced low
    // while reset is held.
    always_comb begin
        load    = !OutValid || OutReady;
        grant_a = ValidA && (!ValidB || (state == PRI_A));
        grant_b = ValidB && (!ValidA || (state == PRI_B));
        ReadyA  = Reset && load && grant_a;
        ReadyB  = Reset && load && grant_b;
        xfer_a  = ValidA && ReadyA;
        xfer_b  = ValidB && ReadyB;
        drain   = OutValid && OutReady;
    end

    // Output stage, priority FSM and transfer counters. A transfer refills
    // the stage (even while it drains, giving one word per cycle); a drain
    // with no refill only clears the valid, leaving word and select intact.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Out      <= '0;
            OutValid <= 1'b0;
            OutSel   <= 1'b0;
            CntA     <= '0;
            CntB     <= '0;
            state    <= PRI_A;
        end else if (xfer_a) begin
            Out      <= InA;
            OutSel   <= 1'b0;
            OutValid <= 1'b1;
            CntA     <= sat_inc(CntA);
            state    <= PRI_B;
        end else if (xfer_b) begin
            Out      <= InB;
            OutSel   <= 1'b1;
            OutValid <= 1'b1;
            CntB     <= sat_inc(CntB);
            state    <= PRI_A;
        end else if (drain) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Testbench for wb_bus_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model. A second instance
// with 4-bit counters shares the stimulus to exercise counter saturation.
module tb_wb_bus_arbiter;

    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [DW-1:0] InA, InB;
    logic          ValidA, ValidB, OutReady;

    logic          ReadyA, ReadyB, OutValid, OutSel;
    logic [DW-1:0] Out;
    logic [15:0]   CntA, CntB;

    logic          s_ready_a, s_ready_b, s_out_valid, s_out_sel;
    logic [DW-1:0] s_out;
    logic [3:0]    s_cnt_a, s_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the word held downstream, who favours a tie,
    // and unbounded transfer counts per source.
    logic [DW-1:0] m_out;
    logic          m_valid;
    logic          m_sel;
    int            m_fav;
    int            m_cnt_a;
    int            m_cnt_b;
    logic          seen_ra, seen_rb;

    always #5 Clk = ~Clk;

    wb_bus_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .InA(InA), .ValidA(ValidA), .ReadyA(ReadyA),
        .InB(InB), .ValidB(ValidB), .ReadyB(ReadyB),
        .Out(Out), .OutValid(OutValid), .OutReady(OutReady), .OutSel(OutSel),
        .CntA(CntA), .CntB(CntB)
    );

    wb_bus_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
        .Clk(Clk), .Reset(Reset),
        .InA(InA), .ValidA(ValidA), .ReadyA(s_ready_a),
        .InB(InB), .ValidB(ValidB), .ReadyB(s_ready_b),
        .Out(s_out), .OutValid(s_out_valid), .OutReady(OutReady), .OutSel(s_out_sel),
        .CntA(s_cnt_a), .CntB(s_cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out"},       64'(Out),         64'(m_out));
        chk({tag, ".valid"},     64'(OutValid),    64'(m_valid));
        chk({tag, ".sel"},       64'(OutSel),      64'(m_sel));
        chk({tag, ".cnt_a"},     64'(CntA),        64'(sat(m_cnt_a, 16)));
        chk({tag, ".cnt_b"},     64'(CntB),        64'(sat(m_cnt_b, 16)));
        chk({tag, ".s_out"},     64'(s_out),       64'(m_out));
        chk({tag, ".s_valid"},   64'(s_out_valid), 64'(m_valid));
        chk({tag, ".s_cnt_a"},   64'(s_cnt_a),     64'(sat(m_cnt_a, 4)));
        chk({tag, ".s_cnt_b"},   64'(s_cnt_b),     64'(sat(m_cnt_b, 4)));
    endtask

    // One clock cycle: drive, check handshake, clock, advance model, check.
    // Called just after a falling edge.
    task automatic step(input logic va, input logic vb, input logic [DW-1:0] ia,
                        input logic [DW-1:0] ib, input logic ordy);
        logic load;
        int   win;
        ValidA = va; ValidB = vb; InA = ia; InB = ib; OutReady = ordy;
        load = !m_valid || ordy;
        win  = -1;
        if (load) begin
            if (va && vb) win = m_fav;
            else if (va)  win = 0;
            else if (vb)  win = 1;
        end
        #1;
        seen_ra = ReadyA;
        seen_rb = ReadyB;
        chk("ready_a",   64'(ReadyA),    64'(win == 0));
        chk("ready_b",   64'(ReadyB),    64'(win == 1));
        chk("s_ready_a", 64'(s_ready_a), 64'(win == 0));
        @(posedge Clk);
        if (win >= 0) begin
            m_out   = (win == 1) ? ib : ia;
            m_sel   = (win == 1);
            m_valid = 1'b1;
            if (win == 1) m_cnt_b++; else m_cnt_a++;
            m_fav   = 1 - win;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs("cyc");
        @(negedge Clk);
    endtask

    task automatic do_reset();
        ValidA = 1'b1; ValidB = 1'b1; OutReady = 1'b1;
        Reset = 1'b0;
        m_out = '0; m_valid = 1'b0; m_sel = 1'b0; m_fav = 0;
        m_cnt_a = 0; m_cnt_b = 0;
        #1;
        check_outputs("rst");
        chk("rst.ready_a", 64'(ReadyA), 64'd0);
        chk("rst.ready_b", 64'(ReadyB), 64'd0);
        @(posedge Clk);
        #1;
        check_outputs("rst_hold");
        @(negedge Clk);
        Reset = 1'b1;
        ValidA = 1'b0; ValidB = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; ValidA = 0; ValidB = 0; InA = '0; InB = '0; OutReady = 0;
        m_out = '0; m_valid = 0; m_sel = 0; m_fav = 0; m_cnt_a = 0; m_cnt_b = 0;
        seen_ra = 0; seen_rb = 0;
        @(negedge Clk);
        do_reset();

        // After reset with both valid, A goes first.
        step(1, 1, 32'h1, 32'h2, 1);
        chk("first_grant_a", 64'(seen_ra), 64'd1);
        chk("first_out", 64'(Out), 64'h1);

        // Single source A, four cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'h0000_1111, 32'h0, 1);
            chk("single.ready_a", 64'(seen_ra), 64'd1);
        end
        chk("single.out", 64'(Out), 64'h0000_1111);
        chk("single.sel", 64'(OutSel), 64'd0);
        chk("single.cnt_a", 64'(CntA), 64'd4);
        chk("single.cnt_b", 64'(CntB), 64'd0);

        // Contention: strict alternation starting with A.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1);
            chk("contend.sel", 64'(OutSel), 64'(i % 2));
            chk("contend.out", 64'(Out), (i % 2) ? 64'hBBBB_BBBB : 64'hAAAA_AAAA);
        end
        chk("contend.cnt_a", 64'(CntA), 64'd3);
        chk("contend.cnt_b", 64'(CntB), 64'd3);

        // Backpressure: B fills, A blocked while downstream stalls.
        do_reset();
        step(0, 1, 32'h0, 32'hDEAD_BEEF, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'h1234_5678, 32'h0, 0);
            chk("stall.ready_a", 64'(seen_ra), 64'd0);
            chk("stall.out", 64'(Out), 64'hDEAD_BEEF);
        end
        step(1, 0, 32'h1234_5678, 32'h0, 1);
        chk("unstall.ready_a", 64'(seen_ra), 64'd1);
        chk("unstall.out", 64'(Out), 64'h1234_5678);

        // Drain with nothing to refill.
        do_reset();
        step(1, 0, 32'h5555_5555, 32'h0, 1);
        step(0, 0, 32'h0, 32'h0, 1);
        chk("drain.valid", 64'(OutValid), 64'd0);
        chk("drain.out", 64'(Out), 64'h5555_5555);

        // Saturation of the 4-bit counter instance.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 32'(i), 32'h0, 1);
        chk("sat.cnt_a4", 64'(s_cnt_a), 64'd15);
        chk("sat.cnt_a16", 64'(CntA), 64'd20);

        // Random traffic with a mid-stream reset.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                if (!m_valid) step(1, 0, $urandom, 32'h0, 1);
                chk("midrst.pre_valid", 64'(OutValid), 64'd1);
                do_reset();
                step(1, 1, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 1);
                chk("midrst.first_a", 64'(seen_ra), 64'd1);
            end
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 $urandom, $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
